sti_dac_p: RTL and testbench

STI_DAC_P -- requirements
Module: sti_dac_p

---
 rtl/sti_dac_p.sv | 185 ++++++++++++++++++
 tb/tb_sti_dac_p.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_dac_p.sv
// sti_dac_p: parallel-to-serial frame shifter with byte packer feeding a
// bank-interleaved pixel memory write port. An end-of-image frame triggers
// a zero fill of every remaining pixel, followed by a sticky finish flag.
module sti_dac_p #(
    parameter int PI_W  = 16,
    parameter int BANK  = 4,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PI_W-1:0] pi_data,
    input  logic [1:0]      pi_length,
    input  logic            pi_fill,
    input  logic            pi_msb,
    input  logic            pi_low,
    input  logic            pi_end,
    output logic            busy,
    output logic            load_drop,
    output logic            so_data,
    output logic            so_valid,
    output logic [AW-1:0]   oem_addr,
    output logic [7:0]      oem_dataout,
    output logic [BANK-1:0] odd_wr,
    output logic [BANK-1:0] even_wr,
    output logic            oem_finish
);

    localparam int FW    = 2 * PI_W;             // widest frame (L=3)
    localparam int HW    = PI_W / 2;
    localparam int CW    = $clog2(FW);           // bit index width
    localparam int TOTAL = 2 * BANK * DEPTH;     // pixels in the image
    localparam int PW    = $clog2(TOTAL) + 1;    // pixel counter, reaches TOTAL
    localparam int QW    = AW + 1;               // pixel offset inside a bank pair

    typedef enum logic [1:0] {IDLE, SHIFT, FILL, DONE} state_t;

    state_t          state;
    logic [FW-1:0]   frame;
    logic [FW-1:0]   frame_in;
    logic [FW-1:0]   data_ext;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   left;
    logic [CW-1:0]   n_m1;
    logic [CW-1:0]   first_idx;
    logic [CW-1:0]   next_idx;
    logic            msb_r;
    logic            end_r;
    logic [7:0]      byte_sr;
    logic [2:0]      bitcnt;
    logic [PW-1:0]   p;
    logic [PW-1:0]   p_after;
    logic [QW-1:0]   q;
    logic            to_odd;
    logic [AW-1:0]   addr_p;
    logic [BANK-1:0] bank_hot;
    logic            room;
    logic            do_write;
    logic [7:0]      wr_data;
    logic [7:0]      full_byte;
    logic [7:0]      flush_byte;

    // Frame formation from the parallel inputs and first bit selection
    always_comb begin
        data_ext  = FW'(pi_data);
        n_m1      = CW'((int'(pi_length) + 1) * HW - 1);
        first_idx = pi_msb ? n_m1 : '0;
        case (pi_length)
            2'd0:    frame_in = pi_low ? FW'(pi_data[PI_W-1:HW]) : FW'(pi_data[HW-1:0]);
            2'd1:    frame_in = data_ext;
            2'd2:    frame_in = pi_fill ? (data_ext << HW) : data_ext;
            default: frame_in = pi_fill ? (data_ext << PI_W) : data_ext;
        endcase
        next_idx = msb_r ? (idx - CW'(1)) : (idx + CW'(1));
    end

    // Pixel address mapping and write selection for the current pixel p
    always_comb begin
        q          = QW'(p);
        to_odd     = q[0] ^ (|(q & QW'(16)));
        addr_p     = q[QW-1:1];
        bank_hot   = BANK'(1) << (p >> QW);
        room       = (p < PW'(TOTAL));
        full_byte  = {byte_sr[6:0], so_data};
        flush_byte = byte_sr << (4'd8 - {1'b0, bitcnt});
        if (state == FILL) begin
            do_write = room;
            wr_data  = (bitcnt != 3'd0) ? flush_byte : 8'h00;
        end else begin
            do_write = so_valid && (bitcnt == 3'd7) && room;
            wr_data  = full_byte;
        end
        p_after = p + PW'(do_write);
    end

    // Control FSM, serializer, byte packer and write port, all registered.
    // The packer taps the registered serial output, which places each byte
    // write exactly one cycle after its 8th bit is on so_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            frame       <= '0;
            idx         <= '0;
            left        <= '0;
            msb_r       <= 1'b0;
            end_r       <= 1'b0;
            byte_sr     <= '0;
            bitcnt      <= '0;
            p           <= '0;
            busy        <= 1'b0;
            load_drop   <= 1'b0;
            so_data     <= 1'b0;
            so_valid    <= 1'b0;
            oem_addr    <= '0;
            oem_dataout <= '0;
            odd_wr      <= '0;
            even_wr     <= '0;
            oem_finish  <= 1'b0;
        end else begin
            odd_wr  <= '0;
            even_wr <= '0;
            if (load && busy) load_drop <= 1'b1;

            if (so_valid) begin
                byte_sr <= full_byte;
                bitcnt  <= bitcnt + 3'd1;
            end

            if (do_write) begin
                oem_addr    <= addr_p;
                oem_dataout <= wr_data;
                if (to_odd) odd_wr  <= bank_hot;
                else        even_wr <= bank_hot;
                p <= p_after;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        frame    <= frame_in;
                        msb_r    <= pi_msb;
                        end_r    <= pi_end;
                        idx      <= first_idx;
                        left     <= n_m1;
                        so_data  <= frame_in[first_idx];
                        so_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (left != '0) begin
                        idx     <= next_idx;
                        left    <= left - CW'(1);
                        so_data <= frame[next_idx];
                    end else begin
                        so_valid <= 1'b0;
                        so_data  <= 1'b0;
                        if (!end_r) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (p_after == PW'(TOTAL)) begin
                            state <= DONE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (room) begin
                        bitcnt  <= '0;
                        byte_sr <= '0;
                    end else begin
                        state      <= DONE;
                        oem_finish <= 1'b1;
                    end
                end
                DONE: oem_finish <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sti_dac_p.sv
// Directed bench for sti_dac_p at default parameters (16-bit input,
// 4+4 banks of 32 pixels).
module tb_sti_dac_p;

    localparam int PI_W  = 16;
    localparam int BANK  = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            load;
    logic [PI_W-1:0] pi_data;
    logic [1:0]      pi_length;
    logic            pi_fill;
    logic            pi_msb;
    logic            pi_low;
    logic            pi_end;
    logic            busy;
    logic            load_drop;
    logic            so_data;
    logic            so_valid;
    logic [AW-1:0]   oem_addr;
    logic [7:0]      oem_dataout;
    logic [BANK-1:0] odd_wr;
    logic [BANK-1:0] even_wr;
    logic            oem_finish;

    sti_dac_p #(.PI_W(PI_W), .BANK(BANK), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
        .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
        .pi_low(pi_low), .pi_end(pi_end), .busy(busy), .load_drop(load_drop),
        .so_data(so_data), .so_valid(so_valid), .oem_addr(oem_addr),
        .oem_dataout(oem_dataout), .odd_wr(odd_wr), .even_wr(even_wr),
        .oem_finish(oem_finish)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Write log, indexed by write order (equal to pixel index after reset)
    int         wr_cnt = 0;
    logic       log_odd  [512];
    int         log_bank [512];
    logic [4:0] log_addr [512];
    logic [7:0] log_data [512];
    int         hits [2][BANK][DEPTH];

    function automatic int hot_idx(input logic [3:0] v);
        int r = -1;
        for (int b = 0; b < 4; b++) if (v == (4'b0001 << b)) r = b;
        return r;
    endfunction

    function automatic logic [31:0] rev8(input logic [7:0] v);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Records every write strobe seen on the memory port
    always @(negedge clk) begin : mon
        int b;
        if (reset) begin
            wr_cnt = 0;
            foreach (hits[i, j, k]) hits[i][j][k] = 0;
        end else if ((odd_wr | even_wr) != 4'b0000) begin
            b = (odd_wr != 4'b0000 && even_wr != 4'b0000) ? -1 : hot_idx(odd_wr | even_wr);
            if (wr_cnt < 512) begin
                log_odd[wr_cnt]  = (odd_wr != 4'b0000);
                log_bank[wr_cnt] = b;
                log_addr[wr_cnt] = oem_addr;
                log_data[wr_cnt] = oem_dataout;
            end
            if (b >= 0) hits[(odd_wr != 4'b0000) ? 1 : 0][b][oem_addr]++;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Loads one frame and checks the serial stream; bits[i] is the i-th
    // transmitted bit. Returns at the sample one cycle after the last bit.
    task automatic run_frame(input logic [1:0] len, input logic [15:0] data,
                             input logic fill, input logic msb, input logic low,
                             input logic endf, input logic [31:0] bits,
                             input int pulse_at, input string tag);
        int n;
        n = (int'(len) + 1) * 8;
        pi_length = len; pi_data = data; pi_fill = fill;
        pi_msb = msb; pi_low = low; pi_end = endf; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(so_valid), 32'd1);
            chk({tag, "_bit"},   32'(so_data),  32'(bits[i]));
            chk({tag, "_busy"},  32'(busy),     32'd1);
            if (i == pulse_at) begin
                load = 1'b1; pi_data = 16'hFFFF; pi_length = 2'd3;
            end else begin
                load = 1'b0;
            end
            if (i < n - 1) @(negedge clk);
        end
        load = 1'b0;
        @(negedge clk);
        chk({tag, "_end"}, 32'(so_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int zeros;
        int bad;

        reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
        pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_so",    32'({so_valid, so_data}), 32'd0);
        chk("rst_wr",    32'({odd_wr, even_wr}), 32'd0);
        chk("rst_oem",   32'({oem_addr, oem_dataout}), 32'd0);
        chk("rst_flags", 32'({load_drop, oem_finish}), 32'd0);
        reset = 1'b0;

        // L=0 upper half MSB first, loaded on the first edge after reset
        run_frame(2'd0, 16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000A5, -1, "f42");
        chk("f42_even", 32'(even_wr), 32'h1);
        chk("f42_odd",  32'(odd_wr), 32'h0);
        chk("f42_addr", 32'(oem_addr), 32'd0);
        chk("f42_data", 32'(oem_dataout), 32'hA5);
        chk("f42_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("f42_pulse", 32'({odd_wr, even_wr}), 32'd0);
        chk("f42_hold",  32'({oem_addr, oem_dataout}), 32'h0A5);

        // L=3 zero-extended, LSB first: bits 1,0x14,1,0x16 -> bytes 80 01 00 00
        run_frame(2'd3, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00008001, -1, "f43");
        chk("f43_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("f43_p1_odd",  32'(log_odd[1]), 32'd1);
        chk("f43_p1_addr", 32'(log_addr[1]), 32'd0);
        chk("f43_p1_data", 32'(log_data[1]), 32'h80);
        chk("f43_p2_odd",  32'(log_odd[2]), 32'd0);
        chk("f43_p2_addr", 32'(log_addr[2]), 32'd1);
        chk("f43_p2_data", 32'(log_data[2]), 32'h01);
        chk("f43_p4_data", 32'(log_data[4]), 32'h00);

        // L=1 MSB first with a load pulse during bit 3
        chk("f44_drop_pre", 32'(load_drop), 32'd0);
        run_frame(2'd1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00002C48, 3, "f44");
        chk("f44_drop_set", 32'(load_drop), 32'd1);
        chk("f44_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("f44_p5_data",  32'(log_data[5]), 32'h12);
        chk("f44_p6_data",  32'(log_data[6]), 32'h34);
        chk("f44_drop_hold", 32'(load_drop), 32'd1);

        // Stream pixels 7..16 as single bytes, then 12 four-byte frames to p=64
        for (int k = 7; k <= 16; k++)
            run_frame(2'd0, {8'hEE, 8'(k)}, 1'b0, 1'b1, 1'b0, 1'b0, rev8(8'(k)), -1, "f45a");
        for (int k = 0; k < 12; k++)
            run_frame(2'd3, 16'h5A3C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3C5A0000, -1, "f45b");
        @(negedge clk);
        chk("p16_odd",  32'(log_odd[16]), 32'd1);
        chk("p16_bank", log_bank[16], 32'd0);
        chk("p16_addr", 32'(log_addr[16]), 32'd8);
        chk("p16_data", 32'(log_data[16]), 32'h10);
        chk("p63_odd",  32'(log_odd[63]), 32'd0);
        chk("p63_addr", 32'(log_addr[63]), 32'd31);
        chk("p63_data", 32'(log_data[63]), 32'h5A);
        chk("p64_odd",  32'(log_odd[64]), 32'd0);
        chk("p64_bank", log_bank[64], 32'd1);
        chk("p64_addr", 32'(log_addr[64]), 32'd0);
        chk("p64_data", 32'(log_data[64]), 32'h3C);
        chk("p64_count", wr_cnt, 32'd65);

        // Two bytes then end of image: 254 zero fills
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_flags", 32'({load_drop, oem_finish, busy}), 32'd0);
        reset = 1'b0;
        run_frame(2'd0, 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h000000C3, -1, "f46a");
        run_frame(2'd0, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, -1, "f46b");
        cyc = 1;
        while (!oem_finish && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("fin_reached", 32'(oem_finish), 32'd1);
        chk("fin_latency", cyc, 32'd256);
        repeat (5) @(negedge clk);
        chk("fin_hold",  32'(oem_finish), 32'd1);
        chk("fin_total", wr_cnt, 32'd256);
        zeros = 0;
        for (int k = 2; k < 256; k++) if (log_data[k] == 8'h00) zeros++;
        chk("fill_zeros",  zeros, 32'd254);
        chk("fill_p0",     32'(log_data[0]), 32'hC3);
        chk("fill_p1",     32'({log_odd[1], log_data[1]}), 32'h180);
        chk("fill_last",   32'({log_odd[255], log_addr[255], log_data[255]}), 32'h01F00);
        chk("fill_lbank",  log_bank[255], 32'd3);
        bad = 0;
        foreach (hits[i, j, k]) if (hits[i][j][k] != 1) bad++;
        chk("fill_cover", bad, 32'd0);

        // Reset in the middle of the fill, then a fresh frame
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst3_out", 32'({oem_finish, busy, odd_wr, even_wr}), 32'd0);
        reset = 1'b0;
        run_frame(2'd0, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h000000FF, -1, "f47a");
        repeat (20) @(negedge clk);
        chk("f47_p20_wr",   32'({odd_wr, even_wr}), 32'h10);
        chk("f47_p20_addr", 32'(oem_addr), 32'd10);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ctl", 32'({busy, load_drop, so_data, so_valid, oem_finish}), 32'd0);
        chk("mid_rst_wr",  32'({odd_wr, even_wr}), 32'd0);
        chk("mid_rst_oem", 32'({oem_addr, oem_dataout}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_frame(2'd0, 16'h3C00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000003C, -1, "f47b");
        chk("f47_even", 32'(even_wr), 32'h1);
        chk("f47_odd",  32'(odd_wr), 32'h0);
        chk("f47_addr", 32'(oem_addr), 32'd0);
        chk("f47_data", 32'(oem_dataout), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
